// File: rtl/arty_z7_leds_driver.sv
// Four-channel LED driver for the Arty Z7: per-LED OFF/ON/BLINK/BREATHE modes with PWM
// brightness, reconfigured through a one-deep write slot that only commits on PWM period wraps.

module arty_z7_leds_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [1:0]          we_mode,
  input  logic [PWM_BITS-1:0] we_bright,
  input  logic                blink_phase,
  input  logic [PWM_BITS-1:0] ramp,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);
  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;

  logic [1:0]          mode_q, mode_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [PWM_BITS-1:0] duty;
  logic                led_q, led_d;

  always_comb begin
    mode_d   = mode_q;
    bright_d = bright_q;
    if (we) begin
      mode_d   = we_mode;
      bright_d = we_bright;
    end
    duty = '0;
    case (mode_q)
      M_OFF:   duty = '0;
      M_ON:    duty = bright_q;
      M_BLINK: duty = blink_phase ? bright_q : '0;
      default: duty = ramp;
    endcase
    led_d = (pwm_cnt < duty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= M_OFF;
      bright_q <= '0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      bright_q <= bright_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;
endmodule

module arty_z7_leds_driver #(
  parameter int NR_OF_LEDS          = 4,
  parameter int PWM_BITS            = 8,
  parameter int PWM_DIV             = 2,
  parameter int BLINK_HALF_PERIOD   = 62500000,
  parameter int BREATHE_STEP_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(NR_OF_LEDS)-1:0] cfg_led,
  input  logic [1:0]                    cfg_mode,
  input  logic [PWM_BITS-1:0]           cfg_brightness,
  output logic [NR_OF_LEDS-1:0]         led,
  output logic                          pwm_period_start
);
  localparam int LED_W = $clog2(NR_OF_LEDS);
  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int BLK_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam int BRE_W = (BREATHE_STEP_CYCLES > 1) ? $clog2(BREATHE_STEP_CYCLES) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(PWM_DIV - 1);
  localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_HALF_PERIOD - 1);
  localparam logic [BRE_W-1:0]    BRE_LAST = BRE_W'(BREATHE_STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

  typedef struct packed {
    logic [LED_W-1:0]    led;
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] bright;
  } cfg_req_t;

  logic [DIV_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pps_q, pps_d;
  logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [BRE_W-1:0]    bre_cnt_q, bre_cnt_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic                ramp_up_q, ramp_up_d;
  cfg_req_t            pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic                tick, boundary, bre_step, accept, apply;
  logic [NR_OF_LEDS-1:0] lane_we;

  always_comb begin
    tick        = (presc_q == DIV_LAST);
    presc_d     = tick ? '0 : presc_q + DIV_W'(1);
    boundary    = tick && (pwm_cnt_q == PWM_MAX);
    pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    pps_d       = boundary;

    blink_cnt_d   = blink_cnt_q + BLK_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    // Triangle ramp: reaching an endpoint costs one step (value held) while direction flips.
    bre_step  = (bre_cnt_q == BRE_LAST);
    bre_cnt_d = bre_step ? '0 : bre_cnt_q + BRE_W'(1);
    ramp_d    = ramp_q;
    ramp_up_d = ramp_up_q;
    if (bre_step) begin
      if (ramp_up_q) begin
        if (ramp_q == PWM_MAX) ramp_up_d = 1'b0;
        else                   ramp_d    = ramp_q + PWM_BITS'(1);
      end else begin
        if (ramp_q == '0)      ramp_up_d = 1'b1;
        else                   ramp_d    = ramp_q - PWM_BITS'(1);
      end
    end

    // Slot state before this edge decides both: a write landing on a wrap waits one period.
    accept     = cfg_valid && !pend_vld_q;
    apply      = boundary && pend_vld_q;
    pend_d     = pend_q;
    if (accept) begin
      pend_d.led    = cfg_led;
      pend_d.mode   = cfg_mode;
      pend_d.bright = cfg_brightness;
    end
    pend_vld_d = accept || (pend_vld_q && !apply);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      pps_q         <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      bre_cnt_q     <= '0;
      ramp_q        <= '0;
      ramp_up_q     <= 1'b1;
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      pps_q         <= pps_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      bre_cnt_q     <= bre_cnt_d;
      ramp_q        <= ramp_d;
      ramp_up_q     <= ramp_up_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
    end
  end

  assign cfg_ready        = ~pend_vld_q;
  assign pwm_period_start = pps_q;

  // An index with no matching lane simply commits nowhere.
  for (genvar g = 0; g < NR_OF_LEDS; g++) begin : g_lane
    assign lane_we[g] = apply && (pend_q.led == LED_W'(g));
    arty_z7_leds_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .we         (lane_we[g]),
      .we_mode    (pend_q.mode),
      .we_bright  (pend_q.bright),
      .blink_phase(blink_phase_q),
      .ramp       (ramp_q),
      .pwm_cnt    (pwm_cnt_q),
      .led        (led[g])
    );
  end
endmodule

// File: tb/tb_arty_z7_leds_driver.sv
// Scoreboard bench: a time-based reference model predicts led/cfg_ready/pwm_period_start each cycle.
module tb_arty_z7_leds_driver;
  localparam int NL = 4, PB = 4, DIV = 1, BLK = 40, STEP = 2;
  localparam int PMAX = (1 << PB) - 1;
  localparam int P = (PMAX + 1) * DIV;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_ready;
  logic [1:0] cfg_led = '0, cfg_mode = '0;
  logic [PB-1:0] cfg_brightness = '0;
  logic [NL-1:0] led;
  logic pps;

  logic c3_valid = 1'b0, c3_ready, c3_pps;
  logic [1:0] c3_led = '0, c3_mode = '0;
  logic [PB-1:0] c3_br = '0;
  logic [2:0] c3_led_o;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  arty_z7_leds_driver #(.NR_OF_LEDS(NL), .PWM_BITS(PB), .PWM_DIV(DIV),
    .BLINK_HALF_PERIOD(BLK), .BREATHE_STEP_CYCLES(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_led(cfg_led), .cfg_mode(cfg_mode), .cfg_brightness(cfg_brightness),
    .led(led), .pwm_period_start(pps));

  arty_z7_leds_driver #(.NR_OF_LEDS(3), .PWM_BITS(PB), .PWM_DIV(DIV),
    .BLINK_HALF_PERIOD(BLK), .BREATHE_STEP_CYCLES(STEP)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(c3_valid), .cfg_ready(c3_ready),
    .cfg_led(c3_led), .cfg_mode(c3_mode), .cfg_brightness(c3_br),
    .led(c3_led_o), .pwm_period_start(c3_pps));

  // Reference model: everything derives from n = cycles since the last reset edge.
  typedef struct { logic [NL-1:0] led; logic rdy; logic pps; } exp_t;
  exp_t sb[$];
  int n = 0;
  int m_mode[NL], m_br[NL];
  bit m_pend = 0;
  int m_apply_at = 0, m_pled = 0, m_pmode = 0, m_pbr = 0;

  function automatic int ramp_at(int c);
    int r = (c / STEP) % (2 * (PMAX + 1));
    return (r <= PMAX) ? r : (2 * PMAX + 1 - r);
  endfunction

  function automatic int duty_at(int i, int c);
    case (m_mode[i])
      1: return m_br[i];
      2: return ((c / BLK) % 2 == 1) ? m_br[i] : 0;
      3: return ramp_at(c);
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit was_pend;
    if (!rst_n) begin
      n = 0;
      for (int i = 0; i < NL; i++) begin m_mode[i] = 0; m_br[i] = 0; end
      m_pend = 0;
      e.led = '0; e.rdy = 1'b1; e.pps = 1'b0;
    end else begin
      for (int i = 0; i < NL; i++) e.led[i] = (((n / DIV) % (PMAX + 1)) < duty_at(i, n));
      was_pend = m_pend;
      if (was_pend && (n + 1 == m_apply_at)) begin
        if (m_pled < NL) begin m_mode[m_pled] = m_pmode; m_br[m_pled] = m_pbr; end
        m_pend = 0;
      end
      if (cfg_valid && !was_pend) begin
        m_pend = 1; m_pled = int'(cfg_led); m_pmode = int'(cfg_mode); m_pbr = int'(cfg_brightness);
        m_apply_at = ((n + 1) / P + 1) * P;
      end
      n = n + 1;
      e.rdy = !m_pend;
      e.pps = (n % P == 0);
    end
    sb.push_back(e);
  end

  int cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (led !== e.led || cfg_ready !== e.rdy || pps !== e.pps) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d n=%0d led=%b want %b ready=%b want %b pps=%b want %b",
                 cyc, n, led, e.led, cfg_ready, e.rdy, pps, e.pps);
      end
    end
  end

  task automatic chk(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic idle(input int cycles);
    cfg_valid = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      cfg_led = 2'($urandom); cfg_mode = 2'($urandom); cfg_brightness = PB'($urandom);
      @(negedge clk);
    end
  endtask

  // Returns at the negedge after the accepting edge with cfg_valid still high.
  task automatic do_write(input int l, input int m, input int b);
    bit ok = 0;
    cfg_valid = 1'b1; cfg_led = 2'(l); cfg_mode = 2'(m); cfg_brightness = PB'(b);
    for (int k = 0; k < 200; k++) begin
      ok = (cfg_ready === 1'b1);
      @(negedge clk);
      if (ok) break;
    end
    chk("write_handshake", ok, int'(ok), 1);
  endtask

  task automatic c3_write(input int l, input int m, input int b);
    bit ok = 0;
    c3_valid = 1'b1; c3_led = 2'(l); c3_mode = 2'(m); c3_br = PB'(b);
    for (int k = 0; k < 50; k++) begin
      ok = (c3_ready === 1'b1);
      @(negedge clk);
      if (ok) break;
    end
    c3_valid = 1'b0;
    chk("c3_handshake", ok, int'(ok), 1);
    chk("c3_ready_low", c3_ready === 1'b0, int'(c3_ready), 0);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (c3_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("c3_ready_back", ok, int'(c3_ready), 1);
  endtask

  initial begin
    bit ok;
    int hi;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    do_write(0, 1, 4);  idle(40);
    do_write(0, 1, 0);  idle(40);
    do_write(0, 1, 15); idle(40);
    do_write(1, 2, 15); idle(170);
    do_write(2, 3, 7);  idle(140);
    do_write(3, 1, 9);  do_write(3, 2, 3); idle(40);
    ok = 0;
    for (int k = 0; k < 4 * P; k++) begin
      if ((n % P == P - 1) && cfg_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("boundary_slot_found", ok, n % P, P - 1);
    do_write(0, 1, 10); idle(40);
    for (int r = 0; r < 40; r++) begin
      do_write(int'($urandom_range(0, NL - 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, PMAX)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 20)));
    end
    idle(40);
    do_write(0, 1, 5); do_write(1, 2, 12); do_write(2, 3, 0); do_write(3, 1, 15);
    do_write(0, 1, 3);
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(60);

    c3_write(3, 1, 15);
    ok = 1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (c3_led_o !== 3'b000) ok = 0;
    end
    chk("c3_out_of_range_dark", ok, int'(c3_led_o), 0);
    c3_write(2, 1, 15);
    @(negedge clk);
    hi = 0; ok = 1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (c3_led_o[2] === 1'b1) hi++;
      if (c3_led_o[1:0] !== 2'b00) ok = 0;
    end
    chk("c3_led2_duty15", hi == 15, hi, 15);
    chk("c3_others_dark", ok, int'(c3_led_o[1:0]), 0);
    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
